// File: rtl/mdu_ctrl_if.sv
// EXE-stage <-> multiply/divide unit bundle. The instruction leaves EXE on
// es_valid && md_ready_go && ms_allowin; md_ready_go never depends on ms_allowin.
interface mdu_ctrl_if;
  logic        es_valid;
  logic        ms_allowin;
  logic [5:0]  md_op;
  logic [31:0] md_src1;
  logic [31:0] md_src2;
  logic        md_ready_go;
  logic        md_busy;
  logic [31:0] hi_rdata;
  logic [31:0] lo_rdata;

  modport master (
    output es_valid, ms_allowin, md_op, md_src1, md_src2,
    input  md_ready_go, md_busy, hi_rdata, lo_rdata
  );

  modport slave (
    input  es_valid, ms_allowin, md_op, md_src1, md_src2,
    output md_ready_go, md_busy, hi_rdata, lo_rdata
  );
endinterface

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide control: single-cycle mult/multu/mthi/mtlo and a
// 32-step restoring divider that stalls EXE until the quotient is ready.
module mdu_ctrl (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] o_dbg_state,
  mdu_ctrl_if.slave  mdu
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_rem;
  logic [31:0] r_divisor;
  logic        r_q_neg;
  logic        r_r_neg;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_op_div, w_op_divu, w_op_mult, w_op_multu, w_op_mthi, w_op_mtlo;
  logic        w_src1_neg, w_src2_neg;
  logic [31:0] w_abs1, w_abs2;
  logic        w_no_borrow;
  logic [31:0] w_sub;
  logic [63:0] w_rem_next;
  logic [31:0] w_quot, w_remd;
  logic [63:0] w_mul_a, w_mul_b, w_prod;
  logic        w_div_start;
  logic        w_hi_we, w_lo_we;
  logic [31:0] w_hi_wd, w_lo_wd;

  // Priority decode: div beats everything, mtlo loses to everything.
  assign w_op_div   = mdu.md_op[5];
  assign w_op_divu  = ~mdu.md_op[5] & mdu.md_op[4];
  assign w_op_mult  = ~(|mdu.md_op[5:4]) & mdu.md_op[3];
  assign w_op_multu = ~(|mdu.md_op[5:3]) & mdu.md_op[2];
  assign w_op_mthi  = ~(|mdu.md_op[5:2]) & mdu.md_op[1];
  assign w_op_mtlo  = ~(|mdu.md_op[5:1]) & mdu.md_op[0];

  assign w_src1_neg = w_op_div & mdu.md_src1[31];
  assign w_src2_neg = w_op_div & mdu.md_src2[31];
  assign w_abs1     = w_src1_neg ? (32'd0 - mdu.md_src1) : mdu.md_src1;
  assign w_abs2     = w_src2_neg ? (32'd0 - mdu.md_src2) : mdu.md_src2;

  // Trial subtract uses the bit shifted out of [63] so large divisors still work.
  assign w_no_borrow = (r_rem[63:31] >= {1'b0, r_divisor});
  assign w_sub       = r_rem[62:31] - r_divisor;
  assign w_rem_next  = w_no_borrow ? {w_sub, r_rem[30:0], 1'b1}
                                   : {r_rem[62:0], 1'b0};
  assign w_quot      = r_q_neg ? (32'd0 - w_rem_next[31:0])  : w_rem_next[31:0];
  assign w_remd      = r_r_neg ? (32'd0 - w_rem_next[63:32]) : w_rem_next[63:32];

  assign w_mul_a = {{32{w_op_mult & mdu.md_src1[31]}}, mdu.md_src1};
  assign w_mul_b = {{32{w_op_mult & mdu.md_src2[31]}}, mdu.md_src2};
  assign w_prod  = w_mul_a * w_mul_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    mdu.md_ready_go = 1'b1;
    mdu.md_busy     = 1'b0;
    w_div_start     = 1'b0;
    w_hi_we         = 1'b0;
    w_lo_we         = 1'b0;
    w_hi_wd         = r_hi;
    w_lo_wd         = r_lo;
    case (r_state)
      S_IDLE: begin
        if (mdu.es_valid && (w_op_div || w_op_divu)) begin
          mdu.md_ready_go = 1'b0;
          w_div_start     = 1'b1;
          w_next_state    = S_DIV;
        end else if (mdu.es_valid && mdu.ms_allowin) begin
          if (w_op_mult || w_op_multu) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_hi_wd = w_prod[63:32];
            w_lo_wd = w_prod[31:0];
          end else if (w_op_mthi) begin
            w_hi_we = 1'b1;
            w_hi_wd = mdu.md_src1;
          end else if (w_op_mtlo) begin
            w_lo_we = 1'b1;
            w_lo_wd = mdu.md_src1;
          end
        end
      end
      S_DIV: begin
        mdu.md_ready_go = 1'b0;
        mdu.md_busy     = 1'b1;
        if (r_cnt == 5'd31) begin
          w_next_state = S_DONE;
          w_hi_we      = 1'b1;
          w_lo_we      = 1'b1;
          w_hi_wd      = w_remd;
          w_lo_wd      = w_quot;
        end
      end
      S_DONE: begin
        if (mdu.ms_allowin) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= 5'd0;
      r_rem     <= 64'd0;
      r_divisor <= 32'd0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      if (w_div_start) begin
        r_rem     <= {32'd0, w_abs1};
        r_divisor <= w_abs2;
        r_q_neg   <= w_src1_neg ^ w_src2_neg;
        r_r_neg   <= w_src1_neg;
        r_cnt     <= 5'd0;
      end else if (r_state == S_DIV) begin
        r_rem <= w_rem_next;
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_hi_we) r_hi <= w_hi_wd;
      if (w_lo_we) r_lo <= w_lo_wd;
    end
  end

  assign mdu.hi_rdata = r_hi;
  assign mdu.lo_rdata = r_lo;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scenario bench for mdu_ctrl: directed HI/LO vectors, division timing and
// abort, plus a randomized multiply/divide run against a reference model.
module tb_mdu_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  mdu_ctrl_if mif ();

  mdu_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .o_dbg_state (dbg_state),
    .mdu         (mif)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  localparam logic [5:0] OP_DIV   = 6'b100000;
  localparam logic [5:0] OP_DIVU  = 6'b010000;
  localparam logic [5:0] OP_MULT  = 6'b001000;
  localparam logic [5:0] OP_MULTU = 6'b000100;
  localparam logic [5:0] OP_MTHI  = 6'b000010;
  localparam logic [5:0] OP_MTLO  = 6'b000001;

  // Reference model: HI/LO via plain SV arithmetic, pushes the expected pair.
  task automatic model_push(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    logic        sgn;
    longint      sa, sb;
    longint unsigned pa, pb;
    if (op[5] || op[4]) begin
      sgn = op[5];
      ua  = (sgn && a[31]) ? -a : a;
      ub  = (sgn && b[31]) ? -b : b;
      if (ub == 32'd0) begin
        q = 32'hFFFF_FFFF;
        r = ua;
      end else begin
        q = ua / ub;
        r = ua % ub;
      end
      m_lo = (sgn && (a[31] ^ b[31])) ? -q : q;
      m_hi = (sgn && a[31]) ? -r : r;
    end else if (op[3]) begin
      sa = $signed(a);
      sb = $signed(b);
      {m_hi, m_lo} = sa * sb;
    end else if (op[2]) begin
      pa = a;
      pb = b;
      {m_hi, m_lo} = pa * pb;
    end else if (op[1]) begin
      m_hi = a;
    end else if (op[0]) begin
      m_lo = a;
    end
    exp_q.push_back({m_hi, m_lo});
  endtask

  // Driver: starts at posedge+1, holds the instruction until it fires, ends at posedge+1.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy_cyc, output int first_rdy);
    bit ok;
    ok             = 1'b0;
    busy_cyc       = 0;
    first_rdy      = -1;
    mif.es_valid   = 1'b1;
    mif.md_op      = op;
    mif.md_src1    = a;
    mif.md_src2    = b;
    mif.ms_allowin = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mif.md_busy === 1'b1) busy_cyc++;
      if (mif.md_ready_go === 1'b1) begin
        first_rdy = i;
        ok        = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    mif.es_valid = 1'b0;
    mif.md_op    = 6'd0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL issue_timeout op=%b got no md_ready_go within 100 cycles", op);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    total++; if (mif.md_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", mif.md_busy); end
    total++; if (mif.md_ready_go !== 1'b1) begin bad++; $display("FAIL reset_ready_go got=%b exp=1", mif.md_ready_go); end
    total++; if (mif.hi_rdata !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", mif.hi_rdata); end
    total++; if (mif.lo_rdata !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", mif.lo_rdata); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_divu_basic();
    int bc, fr;
    logic [63:0] e;
    exp_q.push_back({32'd2, 32'd14});
    {m_hi, m_lo} = {32'd2, 32'd14};
    issue(OP_DIVU, 32'd100, 32'd7, bc, fr);
    total++; if (bc != 32) begin bad++; $display("FAIL divu_busy_cycles got=%0d exp=32", bc); end
    total++; if (fr != 33) begin bad++; $display("FAIL divu_latency got=%0d exp=33", fr); end
    e = exp_q.pop_front();
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== e) begin bad++; $display("FAIL divu_100_7 got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, e); end
  endtask

  task automatic test_div_signed();
    int bc, fr;
    logic [63:0] e;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    {m_hi, m_lo} = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, bc, fr);
    e = exp_q.pop_front();
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== e) begin bad++; $display("FAIL div_m7_2 got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, e); end
    // Signed divide by zero: quotient all-ones negated, remainder keeps dividend.
    exp_q.push_back({32'hFFFF_FFF7, 32'h0000_0001});
    {m_hi, m_lo} = {32'hFFFF_FFF7, 32'h0000_0001};
    issue(OP_DIV, 32'hFFFF_FFF7, 32'd0, bc, fr);
    e = exp_q.pop_front();
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== e) begin bad++; $display("FAIL div_m9_0 got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, e); end
  endtask

  task automatic test_mult();
    int bc, fr;
    logic [63:0] e;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFE});
    {m_hi, m_lo} = {32'hFFFF_FFFF, 32'hFFFF_FFFE};
    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, bc, fr);
    total++; if (fr != 0) begin bad++; $display("FAIL mult_latency got=%0d exp=0", fr); end
    e = exp_q.pop_front();
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== e) begin bad++; $display("FAIL mult_m1_2 got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, e); end
    exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
    {m_hi, m_lo} = {32'h0000_0001, 32'hFFFF_FFFE};
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, bc, fr);
    e = exp_q.pop_front();
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== e) begin bad++; $display("FAIL multu_ff_2 got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, e); end
  endtask

  task automatic test_div_zero_hold();
    bit ok;
    logic [63:0] e;
    ok = 1'b0;
    exp_q.push_back({32'h0000_0005, 32'hFFFF_FFFF});
    {m_hi, m_lo} = {32'h0000_0005, 32'hFFFF_FFFF};
    mif.es_valid   = 1'b1;
    mif.md_op      = OP_DIVU;
    mif.md_src1    = 32'd5;
    mif.md_src2    = 32'd0;
    mif.ms_allowin = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mif.md_ready_go === 1'b1) begin ok = 1'b1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL divzero_timeout got no md_ready_go exp ready within 60"); end
    e = exp_q[0];
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL divzero_hold_state k=%0d got=%0d exp=2", k, dbg_state); end
      total++; if ({mif.hi_rdata, mif.lo_rdata} !== e) begin bad++; $display("FAIL divzero_hold_hilo k=%0d got=%h exp=%h", k, {mif.hi_rdata, mif.lo_rdata}, e); end
    end
    mif.ms_allowin = 1'b1;
    @(posedge clk);
    #1;
    mif.es_valid = 1'b0;
    mif.md_op    = 6'd0;
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL divzero_release_state got=%0d exp=0", dbg_state); end
    e = exp_q.pop_front();
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== e) begin bad++; $display("FAIL divu_5_0 got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, e); end
  endtask

  task automatic test_mthi_mtlo();
    logic [63:0] e;
    mif.es_valid   = 1'b1;
    mif.ms_allowin = 1'b1;
    mif.md_op      = OP_MTHI;
    mif.md_src1    = 32'h1234_5678;
    mif.md_src2    = 32'd0;
    model_push(OP_MTHI, 32'h1234_5678, 32'd0);
    @(negedge clk);
    total++; if (mif.md_ready_go !== 1'b1) begin bad++; $display("FAIL mthi_ready got=%b exp=1", mif.md_ready_go); end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== e) begin bad++; $display("FAIL mthi_visible got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, e); end
    mif.md_op   = OP_MTLO;
    mif.md_src1 = 32'h9ABC_DEF0;
    model_push(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
    @(posedge clk);
    #1;
    mif.es_valid = 1'b0;
    mif.md_op    = 6'd0;
    e = exp_q.pop_front();
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== e) begin bad++; $display("FAIL mtlo_visible got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, e); end
  endtask

  task automatic test_priority();
    int bc, fr;
    logic [63:0] e;
    model_push(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    issue(6'b100100, 32'hFFFF_FFF9, 32'd2, bc, fr);
    total++; if (fr != 33) begin bad++; $display("FAIL prio_div_latency got=%0d exp=33", fr); end
    e = exp_q.pop_front();
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== e) begin bad++; $display("FAIL prio_div_multu got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, e); end
    model_push(OP_MTHI, 32'hCAFE_F00D, 32'd0);
    issue(6'b000011, 32'hCAFE_F00D, 32'd0, bc, fr);
    e = exp_q.pop_front();
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== e) begin bad++; $display("FAIL prio_mthi_mtlo got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, e); end
  endtask

  task automatic test_no_fire();
    mif.es_valid   = 1'b1;
    mif.ms_allowin = 1'b0;
    mif.md_op      = OP_MULT;
    mif.md_src1    = 32'd7;
    mif.md_src2    = 32'd9;
    @(negedge clk);
    total++; if (mif.md_ready_go !== 1'b1) begin bad++; $display("FAIL nofire_ready got=%b exp=1", mif.md_ready_go); end
    @(negedge clk);
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== {m_hi, m_lo}) begin bad++; $display("FAIL nofire_mult_hilo got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, {m_hi, m_lo}); end
    mif.es_valid   = 1'b0;
    mif.ms_allowin = 1'b1;
    mif.md_op      = OP_DIV;
    @(negedge clk);
    total++; if (dbg_state !== 2'd0 || mif.md_busy !== 1'b0) begin bad++; $display("FAIL novalid_div state=%0d busy=%b exp state=0 busy=0", dbg_state, mif.md_busy); end
    total++; if (mif.md_ready_go !== 1'b1) begin bad++; $display("FAIL novalid_ready got=%b exp=1", mif.md_ready_go); end
    mif.md_op = 6'd0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int bc, fr, sel;
    logic [5:0]  op;
    logic [31:0] a, b;
    logic [63:0] e;
    for (int n = 0; n < 12; n++) begin
      sel = $urandom_range(0, 3);
      op  = (sel == 0) ? OP_DIV : (sel == 1) ? OP_DIVU : (sel == 2) ? OP_MULT : OP_MULTU;
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      model_push(op, a, b);
      issue(op, a, b, bc, fr);
      total++;
      if ((sel < 2 && (fr != 33 || bc != 32)) || (sel >= 2 && (fr != 0 || bc != 0))) begin
        bad++;
        $display("FAIL rand_timing n=%0d op=%b got lat=%0d busy=%0d", n, op, fr, bc);
      end
      e = exp_q.pop_front();
      total++;
      if ({mif.hi_rdata, mif.lo_rdata} !== e) begin
        bad++;
        $display("FAIL rand_hilo n=%0d op=%b a=%h b=%h got=%h exp=%h", n, op, a, b, {mif.hi_rdata, mif.lo_rdata}, e);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    mif.es_valid   = 1'b1;
    mif.ms_allowin = 1'b1;
    mif.md_op      = OP_DIVU;
    mif.md_src1    = 32'h0000_FFFF;
    mif.md_src2    = 32'd3;
    for (int i = 0; i <= 10; i++) @(negedge clk);
    total++; if (mif.md_busy !== 1'b1 || dbg_state !== 2'd1) begin bad++; $display("FAIL middiv_busy busy=%b state=%0d exp busy=1 state=1", mif.md_busy, dbg_state); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    mif.es_valid = 1'b0;
    mif.md_op    = 6'd0;
    {m_hi, m_lo} = 64'd0;
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
    total++; if (mif.md_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", mif.md_busy); end
    total++; if ({mif.hi_rdata, mif.lo_rdata} !== {m_hi, m_lo}) begin bad++; $display("FAIL abort_hilo got=%h exp=%h", {mif.hi_rdata, mif.lo_rdata}, {m_hi, m_lo}); end
    @(negedge clk);
    total++; if (dbg_state !== 2'd0 || mif.md_ready_go !== 1'b1) begin bad++; $display("FAIL abort_idle state=%0d ready=%b exp state=0 ready=1", dbg_state, mif.md_ready_go); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    mif.es_valid   = 1'b0;
    mif.ms_allowin = 1'b1;
    mif.md_op      = 6'd0;
    mif.md_src1    = 32'd0;
    mif.md_src2    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_mult();
    test_div_zero_hold();
    test_mthi_mtlo();
    test_priority();
    test_no_fire();
    test_random();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
